// File: rtl/mips_alu_pkg.sv
// mips_alu_pkg: shared ALU opcodes, R-type funct codes and ALU-control encodings
package mips_alu_pkg;
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_NOR = 4'b0100;
  localparam logic [3:0] ALU_XOR = 4'b0101;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_SLLV = 6'h04;
  localparam logic [5:0] FUNCT_SRLV = 6'h06;
  localparam logic [5:0] FUNCT_SRAV = 6'h07;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [1:0] ALU_CTRL_ADD   = 2'b00;
  localparam logic [1:0] ALU_CTRL_SUB   = 2'b01;
  localparam logic [1:0] ALU_CTRL_FUNCT = 2'b10;
  localparam logic [1:0] ALU_CTRL_IMM   = 2'b11;
endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: maps ALU-control, funct and I-type op to the alu opcode and shift-source flag
module alu_ctrl_decode
  import mips_alu_pkg::*;
#(
  parameter int BITS_OP = 4
) (
  input  logic [1:0]         alu_ctrl,
  input  logic [5:0]         funct,
  input  logic [BITS_OP-1:0] imm_op,
  output logic [BITS_OP-1:0] op,
  output logic               flag_shamt
);
  logic [3:0] r_op;
  logic       r_flag;
  always_comb begin
    r_op   = ALU_ADD;
    r_flag = 1'b0;
    case (funct)
      FUNCT_SUB, FUNCT_SUBU: r_op = ALU_SUB;
      FUNCT_AND:             r_op = ALU_AND;
      FUNCT_OR:              r_op = ALU_OR;
      FUNCT_XOR:             r_op = ALU_XOR;
      FUNCT_NOR:             r_op = ALU_NOR;
      FUNCT_SLT:             r_op = ALU_SLT;
      FUNCT_SLL:             begin r_op = ALU_SLL; r_flag = 1'b1; end
      FUNCT_SRL:             begin r_op = ALU_SRL; r_flag = 1'b1; end
      FUNCT_SRA:             begin r_op = ALU_SRA; r_flag = 1'b1; end
      FUNCT_SLLV:            r_op = ALU_SLL;
      FUNCT_SRLV:            r_op = ALU_SRL;
      FUNCT_SRAV:            r_op = ALU_SRA;
      default:               r_op = ALU_ADD;
    endcase
  end
  assign op = alu_ctrl == ALU_CTRL_FUNCT ? BITS_OP'(r_op) :
              alu_ctrl == ALU_CTRL_IMM   ? imm_op :
              alu_ctrl == ALU_CTRL_SUB   ? BITS_OP'(ALU_SUB) : BITS_OP'(ALU_ADD);
  assign flag_shamt = alu_ctrl == ALU_CTRL_FUNCT && r_flag;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register feeding the alu, with stall/flush and registered op decode.
// ID_EX_FORWARD_EN enables EX/MEM and MEM/WB forwarding onto the A and rt operands.
module id_ex_stage
  import mips_alu_pkg::*;
#(
  parameter int BITS_SIZE  = 32,
  parameter int BITS_SHAMT = 5,
  parameter int BITS_OP    = 4,
  parameter int BITS_REG   = 5
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic [BITS_SIZE-1:0]  i_rs_data,
  input  logic [BITS_SIZE-1:0]  i_rt_data,
  input  logic [BITS_SIZE-1:0]  i_imm,
  input  logic [BITS_REG-1:0]   i_rs,
  input  logic [BITS_REG-1:0]   i_rt,
  input  logic [BITS_REG-1:0]   i_rd,
  input  logic [BITS_SHAMT-1:0] i_shamt,
  input  logic [5:0]            i_funct,
  input  logic [1:0]            i_alu_ctrl,
  input  logic [BITS_OP-1:0]    i_imm_op,
  input  logic                  i_alu_src,
  input  logic                  i_reg_dst,
  input  logic                  i_regwrite,
  input  logic                  i_memread,
  input  logic                  i_memwrite,
  input  logic                  i_exmem_regwrite,
  input  logic [BITS_REG-1:0]   i_exmem_rd,
  input  logic [BITS_SIZE-1:0]  i_exmem_data,
  input  logic                  i_memwb_regwrite,
  input  logic [BITS_REG-1:0]   i_memwb_rd,
  input  logic [BITS_SIZE-1:0]  i_memwb_data,
  output logic                  o_valid,
  output logic [BITS_SIZE-1:0]  o_data_a,
  output logic [BITS_SIZE-1:0]  o_data_b,
  output logic [BITS_SHAMT-1:0] o_alu_shamt,
  output logic                  o_flag_shamt,
  output logic [BITS_OP-1:0]    o_op,
  output logic [BITS_SIZE-1:0]  o_store_data,
  output logic [BITS_REG-1:0]   o_dest,
  output logic                  o_regwrite,
  output logic                  o_memread,
  output logic                  o_memwrite
);
  logic [BITS_OP-1:0]   dec_op;
  logic                 dec_flag;
  logic [BITS_SIZE-1:0] rs_q, rt_q, imm_q, a_fwd, rt_fwd;
  logic [BITS_REG-1:0]  rs_idx_q, rt_idx_q;
  logic                 alu_src_q;
  logic                 bubble;
  alu_ctrl_decode #(.BITS_OP(BITS_OP)) u_dec (
    .alu_ctrl   (i_alu_ctrl),
    .funct      (i_funct),
    .imm_op     (i_imm_op),
    .op         (dec_op),
    .flag_shamt (dec_flag)
  );
  // an invalid instruction is loaded as a bubble so it can never write
  assign bubble = i_flush || (!i_stall && !i_valid);
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset || bubble) begin
      o_valid      <= 1'b0;
      rs_q         <= '0;
      rt_q         <= '0;
      imm_q        <= '0;
      rs_idx_q     <= '0;
      rt_idx_q     <= '0;
      o_alu_shamt  <= '0;
      o_flag_shamt <= 1'b0;
      o_op         <= BITS_OP'(ALU_ADD);
      alu_src_q    <= 1'b0;
      o_dest       <= '0;
      o_regwrite   <= 1'b0;
      o_memread    <= 1'b0;
      o_memwrite   <= 1'b0;
    end else if (!i_stall) begin
      o_valid      <= 1'b1;
      rs_q         <= i_rs_data;
      rt_q         <= i_rt_data;
      imm_q        <= i_imm;
      rs_idx_q     <= i_rs;
      rt_idx_q     <= i_rt;
      o_alu_shamt  <= i_shamt;
      o_flag_shamt <= dec_flag;
      o_op         <= dec_op;
      alu_src_q    <= i_alu_src;
      o_dest       <= i_reg_dst ? i_rd : i_rt;
      o_regwrite   <= i_regwrite;
      o_memread    <= i_memread;
      o_memwrite   <= i_memwrite;
    end
  end
`ifdef ID_EX_FORWARD_EN
  // EX/MEM is the younger result, so it wins over MEM/WB
  function automatic logic [BITS_SIZE-1:0] fwd(input logic [BITS_REG-1:0] idx,
                                               input logic [BITS_SIZE-1:0] val);
    return (i_exmem_regwrite && i_exmem_rd != '0 && i_exmem_rd == idx) ? i_exmem_data :
           (i_memwb_regwrite && i_memwb_rd != '0 && i_memwb_rd == idx) ? i_memwb_data : val;
  endfunction
  assign a_fwd  = fwd(rs_idx_q, rs_q);
  assign rt_fwd = fwd(rt_idx_q, rt_q);
`else
  logic unused_fwd;
  assign unused_fwd = ^{i_exmem_regwrite, i_exmem_rd, i_exmem_data,
                        i_memwb_regwrite, i_memwb_rd, i_memwb_data, rs_idx_q, rt_idx_q};
  assign a_fwd  = rs_q;
  assign rt_fwd = rt_q;
`endif
  assign o_data_a     = a_fwd;
  assign o_data_b     = alu_src_q ? imm_q : rt_fwd;
  assign o_store_data = rt_fwd;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed literal checks plus randomized run against a behavioural model of id_ex_stage
module tb_id_ex_stage;
  logic        clk = 1'b0, rst = 1'b1;
  logic        i_valid, i_stall, i_flush, i_alu_src, i_reg_dst, i_regwrite, i_memread, i_memwrite;
  logic [31:0] i_rs_data, i_rt_data, i_imm, i_exmem_data, i_memwb_data;
  logic [4:0]  i_rs, i_rt, i_rd, i_shamt, i_exmem_rd, i_memwb_rd;
  logic [5:0]  i_funct;
  logic [1:0]  i_alu_ctrl;
  logic [3:0]  i_imm_op;
  logic        i_exmem_regwrite, i_memwb_regwrite;
  logic        o_valid, o_flag_shamt, o_regwrite, o_memread, o_memwrite;
  logic [31:0] o_data_a, o_data_b, o_store_data;
  logic [4:0]  o_alu_shamt, o_dest;
  logic [3:0]  o_op;
  int n_cmp = 0, n_bad = 0;
  logic chk_en = 1'b0;

  id_ex_stage dut (
    .i_clk(clk), .i_reset(rst), .i_valid(i_valid), .i_stall(i_stall), .i_flush(i_flush),
    .i_rs_data(i_rs_data), .i_rt_data(i_rt_data), .i_imm(i_imm), .i_rs(i_rs), .i_rt(i_rt),
    .i_rd(i_rd), .i_shamt(i_shamt), .i_funct(i_funct), .i_alu_ctrl(i_alu_ctrl),
    .i_imm_op(i_imm_op), .i_alu_src(i_alu_src), .i_reg_dst(i_reg_dst), .i_regwrite(i_regwrite),
    .i_memread(i_memread), .i_memwrite(i_memwrite), .i_exmem_regwrite(i_exmem_regwrite),
    .i_exmem_rd(i_exmem_rd), .i_exmem_data(i_exmem_data), .i_memwb_regwrite(i_memwb_regwrite),
    .i_memwb_rd(i_memwb_rd), .i_memwb_data(i_memwb_data), .o_valid(o_valid),
    .o_data_a(o_data_a), .o_data_b(o_data_b), .o_alu_shamt(o_alu_shamt),
    .o_flag_shamt(o_flag_shamt), .o_op(o_op), .o_store_data(o_store_data), .o_dest(o_dest),
    .o_regwrite(o_regwrite), .o_memread(o_memread), .o_memwrite(o_memwrite)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // model holds the raw instruction fields of whatever EX currently contains
  logic        m_valid, m_alu_src, m_rw, m_mr, m_mw;
  logic [31:0] m_rs, m_rt, m_imm;
  logic [4:0]  m_rsi, m_rti, m_shamt, m_dest;
  logic [5:0]  m_funct;
  logic [1:0]  m_ctrl;
  logic [3:0]  m_immop;

  always @(posedge clk or posedge rst) begin
    if (rst || i_flush || (!i_stall && !i_valid)) begin
      {m_valid, m_alu_src, m_rw, m_mr, m_mw} = '0;
      {m_rs, m_rt, m_imm} = '0;
      {m_rsi, m_rti, m_shamt, m_dest} = '0;
      m_funct = '0; m_ctrl = '0; m_immop = '0;
    end else if (!i_stall) begin
      m_valid = 1'b1; m_alu_src = i_alu_src;
      m_rw = i_regwrite; m_mr = i_memread; m_mw = i_memwrite;
      m_rs = i_rs_data; m_rt = i_rt_data; m_imm = i_imm;
      m_rsi = i_rs; m_rti = i_rt; m_shamt = i_shamt;
      m_dest = i_reg_dst ? i_rd : i_rt;
      m_funct = i_funct; m_ctrl = i_alu_ctrl; m_immop = i_imm_op;
    end
  end

  // returns {flag_shamt, op}
  function automatic logic [4:0] ref_dec(input logic [1:0] ctrl, input logic [5:0] f,
                                         input logic [3:0] immop);
    if (ctrl == 2'd0) return 5'h00;
    if (ctrl == 2'd1) return 5'h01;
    if (ctrl == 2'd3) return {1'b0, immop};
    case (f)
      6'h22, 6'h23: return 5'h01;
      6'h24: return 5'h02;
      6'h25: return 5'h03;
      6'h26: return 5'h05;
      6'h27: return 5'h04;
      6'h2A: return 5'h07;
      6'h00: return 5'h18;
      6'h02: return 5'h19;
      6'h03: return 5'h1A;
      6'h04: return 5'h08;
      6'h06: return 5'h09;
      6'h07: return 5'h0A;
      default: return 5'h00;
    endcase
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [4:0] idx, input logic [31:0] val);
`ifdef ID_EX_FORWARD_EN
    if (i_exmem_regwrite && i_exmem_rd != 0 && i_exmem_rd == idx) return i_exmem_data;
    if (i_memwb_regwrite && i_memwb_rd != 0 && i_memwb_rd == idx) return i_memwb_data;
`endif
    return val;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      logic [4:0]  d;
      logic [31:0] rtv;
      d   = ref_dec(m_ctrl, m_funct, m_immop);
      rtv = ref_fwd(m_rti, m_rt);
      chk("m_valid", 32'(o_valid), 32'(m_valid));
      chk("m_data_a", o_data_a, ref_fwd(m_rsi, m_rs));
      chk("m_data_b", o_data_b, m_alu_src ? m_imm : rtv);
      chk("m_store", o_store_data, rtv);
      chk("m_shamt", 32'(o_alu_shamt), 32'(m_shamt));
      chk("m_op", 32'(o_op), 32'(d[3:0]));
      chk("m_flag", 32'(o_flag_shamt), 32'(d[4]));
      chk("m_dest", 32'(o_dest), 32'(m_dest));
      chk("m_ctl", 32'({o_regwrite, o_memread, o_memwrite}), 32'({m_rw, m_mr, m_mw}));
    end
  end

  task automatic idle();
    {i_valid, i_stall, i_flush, i_alu_src, i_reg_dst, i_regwrite, i_memread, i_memwrite} = '0;
    {i_rs_data, i_rt_data, i_imm, i_exmem_data, i_memwb_data} = '0;
    {i_rs, i_rt, i_rd, i_shamt, i_exmem_rd, i_memwb_rd} = '0;
    i_funct = '0; i_alu_ctrl = '0; i_imm_op = '0;
    i_exmem_regwrite = 1'b0; i_memwb_regwrite = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [5:0] ftab [16] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                            6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h3F};

  initial begin
    idle();
    tick(); tick();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_valid", 32'(o_valid), 0);
    // R-type SUB
    i_valid = 1; i_alu_ctrl = 2'b10; i_funct = 6'h22; i_rs_data = 2; i_rt_data = 1;
    i_rs = 2; i_rt = 1; i_rd = 3; i_reg_dst = 1; i_regwrite = 1;
    tick();
    chk("sub_op", 32'(o_op), 32'h1);
    chk("sub_a", o_data_a, 2);
    chk("sub_b", o_data_b, 1);
    chk("sub_valid", 32'(o_valid), 1);
    chk("sub_dest", 32'(o_dest), 3);
    // constant then variable shift
    i_funct = 6'h02; i_shamt = 5'd31;
    tick();
    chk("srl_op", 32'(o_op), 32'h9);
    chk("srl_flag", 32'(o_flag_shamt), 1);
    chk("srl_shamt", 32'(o_alu_shamt), 31);
    i_funct = 6'h06;
    tick();
    chk("srlv_op", 32'(o_op), 32'h9);
    chk("srlv_flag", 32'(o_flag_shamt), 0);
    // asynchronous reset with a valid instruction loaded
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(o_valid), 0);
    chk("arst_op", 32'(o_op), 0);
    chk("arst_a", o_data_a, 0);
    chk("arst_rw", 32'(o_regwrite), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("reload_valid", 32'(o_valid), 1);
    // stall and flush together: flush wins
    i_stall = 1; i_flush = 1;
    tick();
    chk("sf_valid", 32'(o_valid), 0);
    chk("sf_rw", 32'(o_regwrite), 0);
    // immediate operand on B, store data stays rt
    i_stall = 0; i_flush = 0; i_alu_ctrl = 2'b00; i_alu_src = 1; i_imm = 32'hFFFFFFFC;
    i_rt_data = 32'h1234; i_rs_data = 32'h10; i_memwrite = 1;
    tick();
    chk("imm_b", o_data_b, 32'hFFFFFFFC);
    chk("imm_op", 32'(o_op), 0);
    chk("imm_store", o_store_data, 32'h1234);
    // stall holds everything despite changing inputs
    i_stall = 1; i_rs_data = 32'hDEAD; i_alu_ctrl = 2'b01; i_valid = 0; i_imm = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_a", o_data_a, 32'h10);
      chk("stall_b", o_data_b, 32'hFFFFFFFC);
      chk("stall_op", 32'(o_op), 0);
      chk("stall_valid", 32'(o_valid), 1);
      chk("stall_mw", 32'(o_memwrite), 1);
    end
    // invalid instruction loads a bubble
    i_stall = 0;
    tick();
    chk("bub_valid", 32'(o_valid), 0);
    chk("bub_rw", 32'(o_regwrite), 0);
`ifdef ID_EX_FORWARD_EN
    idle();
    i_valid = 1; i_rs = 5; i_rs_data = 32'h11;
    i_exmem_regwrite = 1; i_exmem_rd = 5; i_exmem_data = 32'hAA;
    i_memwb_regwrite = 1; i_memwb_rd = 5; i_memwb_data = 32'hBB;
    tick();
    chk("fwd_exmem", o_data_a, 32'hAA);
    i_exmem_rd = 0;
    #1;
    chk("fwd_memwb", o_data_a, 32'hBB);
`endif
    for (int n = 0; n < 3000; n++) begin
      i_valid = $urandom_range(0, 3) != 0;
      i_stall = $urandom_range(0, 4) == 0;
      i_flush = $urandom_range(0, 7) == 0;
      i_rs_data = $urandom; i_rt_data = $urandom; i_imm = $urandom;
      i_rs = 5'($urandom_range(0, 7)); i_rt = 5'($urandom_range(0, 7)); i_rd = 5'($urandom);
      i_shamt = 5'($urandom); i_funct = ftab[$urandom_range(0, 15)];
      i_alu_ctrl = 2'($urandom); i_imm_op = 4'($urandom);
      {i_alu_src, i_reg_dst, i_regwrite, i_memread, i_memwrite} = 5'($urandom);
      i_exmem_regwrite = 1'($urandom); i_exmem_rd = 5'($urandom_range(0, 7));
      i_memwb_regwrite = 1'($urandom); i_memwb_rd = 5'($urandom_range(0, 7));
      i_exmem_data = $urandom; i_memwb_data = $urandom;
      if (n == 1500) begin
        rst = 1'b1;
        #1;
        chk("rnd_arst_valid", 32'(o_valid), 0);
        rst = 1'b0;
      end
      tick();
    end
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
